// File: rtl/melody_sequencer.sv
// Song-ROM driven note sequencer for the tone generator.
// It fetches note/duration words, holds each note for its beats, then inserts a silent gap.
module melody_sequencer #(
  parameter int BEAT_TICKS = 2500000,
  parameter int GAP_TICKS  = 250000,
  parameter int ADDR_W     = 6,
  parameter int SONG_LEN   = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [6:0]        note,
  output logic              onoff,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_END
  } state_t;

  localparam logic [31:0] BEAT_L    = 32'(BEAT_TICKS);
  localparam logic [31:0] GAP_RELD  = 32'(GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [3:0]        r_code, w_code_nxt;
  logic [6:0]        r_note, w_note_nxt;
  logic              r_onoff, w_onoff_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [4:0]        w_dur;
  logic [31:0]       w_ticks;
  logic              w_tone;
  logic [6:0]        w_onehot;

  // A duration field of 0 encodes 16 beats.
  assign w_dur   = (rom_data[3:0] == 4'd0) ? 5'd16 : {1'b0, rom_data[3:0]};
  assign w_ticks = 32'(w_dur) * BEAT_L;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_code  <= '0;
      r_note  <= '0;
      r_onoff <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_code  <= w_code_nxt;
      r_note  <= w_note_nxt;
      r_onoff <= w_onoff_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_code_nxt  = r_code;
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (play) begin
            w_state_nxt = S_FETCH;
            w_idx_nxt   = '0;
          end
        end
        S_FETCH: w_state_nxt = S_LOAD;
        S_LOAD: begin
          w_code_nxt = rom_data[7:4];
          if (rom_data[7:4] == 4'hF) begin
            w_state_nxt = S_END;
          end else begin
            w_cnt_nxt   = w_ticks - 32'd1;
            w_state_nxt = S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (r_cnt == '0) begin
              w_state_nxt = S_GAP;
              w_cnt_nxt   = GAP_RELD;
            end else begin
              w_cnt_nxt = r_cnt - 32'd1;
            end
          end
        end
        S_GAP: begin
          if (!pause) begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - 32'd1;
            end else if (r_idx == LAST_IDX) begin
              w_state_nxt = S_END;
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_state_nxt = S_FETCH;
            end
          end
        end
        S_END: begin
          w_idx_nxt   = '0;
          w_state_nxt = loop ? S_FETCH : S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state and registered; pause only gates the tone.
  always_comb begin
    w_tone      = (w_code_nxt >= 4'd1) && (w_code_nxt <= 4'd7);
    w_onehot    = 7'd1 << (w_code_nxt - 4'd1);
    w_note_nxt  = '0;
    w_onoff_nxt = 1'b0;
    if (w_state_nxt == S_PLAY && w_tone) begin
      w_note_nxt  = w_onehot;
      w_onoff_nxt = !pause;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (r_state == S_END) && (w_state_nxt == S_IDLE) && !stop;
  end

  assign rom_addr = r_idx;
  assign note     = r_note;
  assign onoff    = r_onoff;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a timeline model of each song feeds a queue
// that a negedge monitor drains against the DUT, plus directed pause/stop/reset checks.
module tb_melody_sequencer;

  localparam int BEAT     = 4;
  localparam int GAP      = 1;
  localparam int AW       = 3;
  localparam int SLEN     = 6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [6:0]    note;
    logic          onoff;
    logic          busy;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          play = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [6:0]    note;
  logic          onoff;
  logic          busy;
  logic          done;

  logic [7:0]    rom [8];
  obs_t          sb [$];
  int            n_vec = 0;
  int            n_miss = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  melody_sequencer #(
    .BEAT_TICKS(BEAT), .GAP_TICKS(GAP), .ADDR_W(AW), .SONG_LEN(SLEN)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .pause(pause), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .note(note), .onoff(onoff), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected observation per cycle while the scoreboard holds entries.
  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      obs_t e, a;
      e = sb.pop_front();
      a = '{addr: rom_addr, note: note, onoff: onoff, busy: busy, done: done};
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL sb_cycle @%0t: got addr=%0d note=%b onoff=%b busy=%b done=%b, expected addr=%0d note=%b onoff=%b busy=%b done=%b",
                 $time, a.addr, a.note, a.onoff, a.busy, a.done,
                 e.addr, e.note, e.onoff, e.busy, e.done);
      end
    end
  end

  task automatic push_n(input int n, input obs_t o);
    repeat (n) sb.push_back(o);
  endtask

  // Reference timeline: each word is fetch+load, then d beats of tone or silence, then the gap.
  task automatic model_song(input bit lp, input int passes);
    for (int p = 0; p < passes; p++) begin
      int i = 0;
      bit fin = 1'b0;
      while (!fin) begin
        int code, d;
        bit tone;
        logic [6:0] nv;
        code = int'(rom[i][7:4]);
        d    = (rom[i][3:0] == 4'd0) ? 16 : int'(rom[i][3:0]);
        push_n(2, '{addr: AW'(i), note: 7'd0, onoff: 1'b0, busy: 1'b1, done: 1'b0});
        if (code == 15) begin
          fin = 1'b1;
        end else begin
          tone = (code >= 1) && (code <= 7);
          nv   = tone ? 7'(1 << (code - 1)) : 7'd0;
          push_n(d * BEAT, '{addr: AW'(i), note: nv, onoff: tone, busy: 1'b1, done: 1'b0});
          push_n(GAP, '{addr: AW'(i), note: 7'd0, onoff: 1'b0, busy: 1'b1, done: 1'b0});
          if (i == SLEN - 1) fin = 1'b1;
          else i++;
        end
      end
      push_n(1, '{addr: AW'(i), note: 7'd0, onoff: 1'b0, busy: 1'b1, done: 1'b0});
      if (!lp) push_n(1, '{addr: '0, note: 7'd0, onoff: 1'b0, busy: 1'b0, done: 1'b1});
    end
  endtask

  task automatic load_rom(input logic [63:0] v);
    for (int k = 0; k < 8; k++) rom[k] = v[8*k +: 8];
  endtask

  task automatic start_play();
    @(posedge clk); #2 play = 1'b1;
    @(posedge clk); #1 play = 1'b0;
  endtask

  task automatic run_song(input logic [63:0] v, input bit lp);
    int n = 0;
    load_rom(v);
    loop = lp;
    start_play();
    model_song(lp, lp ? 2 : 1);
    // A play pulse while busy must be ignored.
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
      if (n == 1) play = 1'b1;
      if (n == 2) play = 1'b0;
    end
    play = 1'b0;
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL sb_timeout: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
    if (lp) begin
      @(posedge clk); #2 stop = 1'b1;
      loop = 1'b0;
      @(posedge clk); #1 stop = 1'b0;
      check("loop_stop_busy", 32'(busy), 32'd0);
      check("loop_stop_addr", 32'(rom_addr), 32'd0);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) rom[k] = 8'hF0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_note", 32'(note), 32'd0);
    check("rst_onoff", 32'(onoff), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_song(64'h0000_0000_0000_F012, 1'b0);
    run_song(64'h0000_0000_00F0_5151, 1'b0);
    run_song(64'h0000_0000_F030_7103, 1'b0);
    run_song(64'h0000_0000_00F0_0121, 1'b1);
    run_song(64'hF0F0_0173_6241_9211, 1'b0);
    for (int s = 0; s < 14; s++) begin
      logic [63:0] v;
      for (int k = 0; k < 8; k++)
        v[8*k +: 8] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      run_song(v, ($urandom_range(0, 3) == 0));
    end

    // Pause for 10 cycles in the middle of a 4-beat note.
    begin
      int hi = 0;
      bit got_done = 1'b0;
      load_rom(64'h0000_0000_0000_F014);
      start_play();
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        if (onoff) hi++;
        if (c == 6) pause = 1'b1;
        if (c == 10) begin
          check("pause_onoff", 32'(onoff), 32'd0);
          check("pause_note_held", 32'(note), 32'd1);
        end
        if (c == 16) pause = 1'b0;
        if (done) begin
          got_done = 1'b1;
          break;
        end
      end
      pause = 1'b0;
      check("pause_done_seen", 32'(got_done), 32'd1);
      check("pause_onoff_total", 32'(hi), 32'(4 * BEAT));
    end
    repeat (2) @(posedge clk);

    // stop and play together mid-song: stop wins, no done pulse afterwards.
    begin
      bit saw_done = 1'b0;
      bit saw_busy = 1'b0;
      load_rom(64'h0000_0000_00F0_2222);
      start_play();
      repeat (11) @(posedge clk);
      #2 stop = 1'b1; play = 1'b1;
      @(posedge clk); #1 stop = 1'b0; play = 1'b0;
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_onoff", 32'(onoff), 32'd0);
      check("stop_addr", 32'(rom_addr), 32'd0);
      check("stop_note", 32'(note), 32'd0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
        if (busy) saw_busy = 1'b1;
      end
      check("stop_no_done", 32'(saw_done), 32'd0);
      check("stop_stays_idle", 32'(saw_busy), 32'd0);
    end

    // Asynchronous reset mid-note and mid-gap.
    load_rom(64'h0000_0000_00F0_1111);
    start_play();
    repeat (3) @(posedge clk);
    #2 check("pre_rst_play_onoff", 32'(onoff), 32'd1);
    #1 rst = 1'b1;
    #1 check("rst_play_onoff", 32'(onoff), 32'd0);
    check("rst_play_note", 32'(note), 32'd0);
    check("rst_play_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    start_play();
    repeat (13) @(posedge clk);
    #2 check("pre_rst_gap_addr", 32'(rom_addr), 32'd1);
    check("pre_rst_gap_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 check("rst_gap_addr", 32'(rom_addr), 32'd0);
    check("rst_gap_busy", 32'(busy), 32'd0);
    check("rst_gap_onoff", 32'(onoff), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Sequences the tone-generator datapath from a song ROM. Each ROM word holds a note code and a duration. The block fetches each word, drives the one-hot `note` select and `onoff` gate of the tone generator for the encoded number of beats, and inserts a short silent gap between notes so that repeated pitches are audible as separate notes. It sits between the board buttons (play/stop/pause/loop) and the tone generator, replacing free-running hard-coded song state counters.

## Interface
- `BEAT_TICKS`, 2500000: clk cycles per beat unit (0.1 s at 25 MHz).
- `GAP_TICKS`, 250000: silent clk cycles after every note or rest; must be ≥1.
- `ADDR_W`, 6: ROM address width.
- `SONG_LEN`, 50: number of ROM words played when no end marker is found; 1..2^ADDR_W.
- `clk` in 1: system clock, 25 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `play` in 1: synchronous start pulse.
- `stop` in 1: synchronous abort pulse.
- `pause` in 1: level; freezes playback while high.
- `loop` in 1: level; sampled at end of song.
- `rom_addr` out ADDR_W: ROM address.
- `rom_data` in 8: synchronous ROM read data, valid 1 cycle after `rom_addr`. Bits [7:4] are the note code; bits [3:0] are the duration in beats, where 0 means 16.
- `note` out 7: one-hot tone select; bit0 = do … bit6 = si.
- `onoff` out 1: tone gate.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the song ends without looping.

## Operation
- Note codes:
  - 0 = rest: `note`=0, `onoff`=0 for the whole duration.
  - 1..7 = do..si: `note`=1<<(code-1), `onoff`=1.
  - 8..14 = reserved; treated as rest.
  - 15 = end marker; its duration field is ignored.
- Internal index `idx` (ADDR_W bits). `rom_addr`=`idx` at all times.
- States and transitions:
  - IDLE: on `play` → FETCH with `idx`=0.
  - FETCH: 1 cycle, address presented → LOAD.
  - LOAD: captures `rom_data`. End marker → END. Otherwise load the tick counter with dur×BEAT_TICKS−1 → PLAY.
  - PLAY: drive the note; decrement the counter each cycle. At 0 → GAP, loading GAP_TICKS−1.
  - GAP: `note`=0, `onoff`=0. At 0 → if `idx`=SONG_LEN−1 then END, else `idx`+1 → FETCH.
  - END: if `loop`=1 → `idx`=0, FETCH. Else pulse `done`, → IDLE.
- `pause` high in PLAY or GAP: counter holds, `onoff` forced 0, `note` holds. On release, resume with the remaining count.
- `pause` has no effect in IDLE, FETCH, LOAD or END; the FSM advances into PLAY/GAP and freezes there.
- `stop` in any state → IDLE next cycle: `idx`=0, outputs cleared, no `done`.
- `stop` and `play` in the same cycle: `stop` wins.
- `play` while `busy` is ignored.
- Tick counter is 32-bit. dur×BEAT_TICKS is computed at 32-bit width; BEAT_TICKS×16 must fit in 32 bits.

## Timing
- Reset values: `rom_addr`=0, `note`=0, `onoff`=0, `busy`=0, `done`=0; state IDLE, counters 0.
- All outputs are registered.
- `play` at cycle t → FETCH at t+1, LOAD at t+2, `note`/`onoff` valid from t+3.
- For a note of d beats with no pause, `onoff` is high exactly d×BEAT_TICKS cycles. It is followed by exactly GAP_TICKS low cycles.
- Per-word period is 2 + d×BEAT_TICKS + GAP_TICKS cycles.
- End marker detected in LOAD → END the next cycle → `done` high the following cycle, together with `busy`=0.
- Loop wrap: END → FETCH of address 0 with no extra idle cycle.
- `rst` asserted mid-note clears `onoff` immediately (asynchronously).

## Test plan
- BEAT_TICKS=4, GAP_TICKS=1, ROM[0]=0x12 (do, 2 beats), ROM[1]=0xF0; pulse `play` at t=0 → `note`=7'b0000001 and `onoff`=1 for cycles 3..10; cycle 11 low; `done` pulse at cycle 15; then `busy`=0.
- Two consecutive 0x51 (sol, 1 beat) words → `onoff` high for 4 cycles, low for 3, high for 4 (GAP + FETCH + LOAD separate the two notes).
- Rest 0x03 then 0x71, BEAT_TICKS=4 → 12 cycles with `onoff`=0 and `note`=0, then si (7'b1000000) for 4 cycles; duration field 0 → note lasts 64 cycles.
- `loop`=1 with 3-word song ending in 0xF0 → after the third LOAD, `rom_addr` returns to 0 and playback restarts; `done` never pulses.
- `pause` high for 10 cycles mid-PLAY → `onoff` low during the pause; total `onoff` high time still d×BEAT_TICKS.
- `stop` and `play` asserted together mid-song → IDLE next cycle with `busy`=0, `onoff`=0, `rom_addr`=0, no `done`; async `rst` mid-GAP → all outputs 0 immediately.
